// File: rtl/load_count_chain.sv
// ---------------------------------------------------------------------------
// load_count_chain
//
// Registered loadable counter stage with programmable modulus, up/down
// direction, optional saturation and a sticky overflow flag. Terminal count
// and carry-out are combinational, so stages chain on the same clock edge
// for wide or BCD counters (upper.cin = lower.cout).
//
// Parameters
//   WIDTH     count register width (1..32)
//   MAX_VAL   terminal value; count range is 0..MAX_VAL
//   SATURATE  0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   sync_clr  synchronous clear of count and flags (highest priority)
//   load_en   synchronous parallel load (clamped to MAX_VAL)
//   load_val  parallel load data
//   cnt_en    local count enable
//   cin       carry-in from lower stage (tie to 1 on the lowest stage)
//   dir       0 = count up, 1 = count down
//   q         current count (registered)
//   tc        terminal count for the current direction (combinational)
//   cout      carry-out = cnt_en & cin & tc (combinational)
//   wrap      one-cycle pulse after a wrap or saturate event (registered)
//   ovf       sticky overflow flag (registered)
// ---------------------------------------------------------------------------
module load_count_chain #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt_en,
    input  logic             cin,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             cout,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic             at_top;
    logic             at_bot;
    logic             step;
    logic [WIDTH-1:0] load_clamped;

    // Terminal detection and carry lookahead (no clock latency)
    always_comb begin
        at_top = (q_q == MAX_VAL);
        at_bot = (q_q == ZERO);
        step   = cnt_en & cin;
    end

    assign tc   = dir ? at_bot : at_top;
    assign cout = step & tc;

    // Out-of-range load data is clamped so q always stays in 0..MAX_VAL
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Next-state: clear > load > step > hold
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;

        if (sync_clr) begin
            q_d   = ZERO;
            ovf_d = 1'b0;
        end else if (load_en) begin
            q_d = load_clamped;
        end else if (step) begin
            if (tc) begin
                // Range end reached: wrap to the opposite end or hold there
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (!SATURATE) begin
                    q_d = dir ? MAX_VAL : ZERO;
                end
            end else begin
                // Terminal compare above guarantees no WIDTH-bit overflow here
                q_d = dir ? (q_q - ONE) : (q_q + ONE);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= ZERO;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/load_count_chain.md
Name: load_count_chain

Overview:
- Registered, parametrised successor to the team's combinational loadable 4-bit counter next-state logic (load/count/hold select plus carry lookahead).
- Holds the count state internally and adds programmable modulus, up/down direction, optional saturation and a sticky overflow flag.
- Carry lookahead stays combinational so instances can be cascaded into wide or BCD counters.

Parameters:
- WIDTH, 4, count register width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, terminal value of the count range 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1).
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sync_clr  input  1  synchronous clear of count and flags.
- load_en  input  1  synchronous parallel load.
- load_val  input  WIDTH  parallel load data.
- cnt_en  input  1  count enable (local).
- cin  input  1  carry-in from the lower stage; tie to 1 on the lowest stage.
- dir  input  1  0 = count up, 1 = count down.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: up and q==MAX_VAL, or down and q==0.
- cout  output  1  carry-out, combinational: cnt_en & cin & tc.
- wrap  output  1  registered one-cycle pulse after a wrap or saturate event.
- ovf  output  1  sticky overflow flag, registered.

Behaviour:
- Reset: rst high forces q=0, wrap=0, ovf=0 immediately, regardless of clk. Release takes effect at the first clk edge after deassertion.
- Priority at each rising edge, highest first:
  1. sync_clr: q<=0, ovf<=0, wrap<=0.
  2. load_en: q<=min(load_val, MAX_VAL); wrap<=0; ovf unchanged.
  3. step (cnt_en & cin): count per the rules below.
  4. otherwise hold: q unchanged, wrap<=0.
- Step, up (dir=0):
  - q<MAX_VAL: q<=q+1.
  - q==MAX_VAL, SATURATE=0: q<=0, wrap<=1.
  - q==MAX_VAL, SATURATE=1: q holds, wrap<=1, ovf<=1.
- Step, down (dir=1):
  - q>0: q<=q-1.
  - q==0, SATURATE=0: q<=MAX_VAL, wrap<=1.
  - q==0, SATURATE=1: q holds, wrap<=1, ovf<=1.
- Wrap in SATURATE=0 also sets ovf<=1.
- Latency: one cycle from control inputs to q, wrap and ovf. Zero cycles from q/dir/cnt_en/cin to tc and cout.
- cout asserts only in the cycle the stage will roll over, so an upper stage steps on the same edge as the lower stage wraps. No ripple delay in clock cycles.
- dir change mid-count takes effect on the next step, with no extra cycle. tc re-evaluates combinationally.
- load_val > MAX_VAL is clamped to MAX_VAL. Example: WIDTH=4, MAX_VAL=9, load 13 -> q=9.
- In-range values only: q is never outside 0..MAX_VAL after reset.
- Arithmetic is WIDTH-bit unsigned. No intermediate value exceeds WIDTH bits because of the terminal compare.
- rst asserted mid-operation overrides every other input, including load_en and sync_clr.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0, up, cnt_en=cin=1, 12 cycles from reset:
  - q runs 0..9, 0, 1.
  - tc=cout=1 only while q=9.
  - wrap=1 only in the cycle after q 9->0; ovf=1 from then.
- Down from load 2: load_val=2 then dir=1 for 4 cycles:
  - q runs 2, 1, 0, 9, 8.
  - cout=1 while q=0.
- SATURATE=1, MAX_VAL=15, up from load 14:
  - q = 14, 15, 15, 15.
  - wrap=1 on each edge held at 15; ovf sticks at 1 until sync_clr.
- Priority: sync_clr=1, load_en=1, load_val=5, cnt_en=1 on the same edge -> q=0, ovf=0. Next cycle, load_en only -> q=5.
- Cascade two MAX_VAL=9 stages, upper cin = lower cout, count 0..99:
  - upper steps on the edge where lower goes 9->0.
  - combined count reaches 99, then 00 with upper cout pulse at 99.
- Async reset at q=7 mid-cycle (no clk edge) -> q=0, ovf=0, wrap=0 immediately. Count resumes from 0 on the first edge after rst falls.
